// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the memory controller: load/store op encodings
//   and the helpers that decode an op into a byte count and direction.
//   Imported by mem_ctrl and by anything that drives lsb_op.
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    // Load/store op encodings carried on lsb_op.
    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    // Number of RAM bytes touched by an op. Anything unrecognised is
    // handled as a full word so the requester still gets a completion.
    function automatic logic [2:0] op_bytes(input logic [5:0] op);
        logic [2:0] n;
        case (op)
            OP_LB, OP_LBU, OP_SB: n = 3'd1;
            OP_LH, OP_LHU, OP_SH: n = 3'd2;
            OP_LW, OP_SW:         n = 3'd4;
            default:              n = 3'd4;
        endcase
        return n;
    endfunction

    // Only the three store encodings write; unknown ops read.
    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Byte idx (0 = least significant) of a little-endian word.
    function automatic logic [7:0] word_byte(input logic [31:0] w,
                                             input logic [1:0]  idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
//   Bundles the three buses around the memory controller:
//     - LSB request/response  (lsb_req/addr/op/wdata -> lsb_ok/rdata)
//     - fetch request/response (if_req/addr -> if_ok/data)
//     - byte-serial RAM/IO port (mem_a/dout/wr <- mem_din, io_buffer_full)
//   slave  : the controller's view (mem_ctrl)
//   master : the requesters' and RAM's view
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    // LSB side
    logic              lsb_req;
    logic [ADDR_W-1:0] lsb_addr;
    logic [5:0]        lsb_op;
    logic [31:0]       lsb_wdata;
    logic              lsb_ok;
    logic [31:0]       lsb_rdata;

    // Instruction-fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ok;
    logic [31:0]       if_data;

    // RAM / IO port
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    modport slave (
        input  lsb_req, lsb_addr, lsb_op, lsb_wdata,
        input  if_req, if_addr,
        input  mem_din, io_buffer_full,
        output lsb_ok, lsb_rdata,
        output if_ok, if_data,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output lsb_req, lsb_addr, lsb_op, lsb_wdata,
        output if_req, if_addr,
        output mem_din, io_buffer_full,
        input  lsb_ok, lsb_rdata,
        input  if_ok, if_data,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Responder for the load/store buffer and the instruction-fetch unit.
//   Turns one byte/half/word request into byte-serial accesses on the
//   8-bit RAM/IO bus and returns a one-cycle ok pulse with the raw bytes.
//
// Ports
//   clk  : system clock
//   rst  : asynchronous active-high reset; aborts any access, no ok issued
//   rdy  : global enable; low freezes all state and drops mem_wr
//   bus  : mem_ctrl_if.slave
//            lsb_req/lsb_addr/lsb_op/lsb_wdata -> lsb_ok/lsb_rdata
//            if_req/if_addr                    -> if_ok/if_data
//            mem_din, io_buffer_full           -> mem_a/mem_dout/mem_wr
//
// Parameters
//   ADDR_W : address width of request and RAM ports
//   IO_HI  : addr[17:16] value marking the memory-mapped IO region; writes
//            there stall while io_buffer_full is high
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        cnt;       // READ: edges seen; WRITE: bytes launched
    logic [2:0]        nbytes;
    logic [ADDR_W-1:0] addr_l;
    logic [31:0]       wdata_l;
    logic [31:0]       rbuf;
    logic              is_fetch;

    logic [1:0]        cap_idx;
    logic [31:0]       rbuf_next;
    logic              lsb_store;
    logic              lsb_stall;
    logic              wr_stall;

    // Read data for mem_a of cycle t arrives in t+1, so on a READ edge with
    // cnt = k the byte on mem_din belongs to index k-1.
    always_comb begin
        cap_idx   = cnt[1:0] - 2'd1;
        rbuf_next = rbuf;
        rbuf_next[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    end

    always_comb begin
        lsb_store = op_is_store(bus.lsb_op);
        // Accept edge checks the incoming address; later edges the latched one.
        lsb_stall = (bus.lsb_addr[17:16] == IO_HI) && bus.io_buffer_full;
        wr_stall  = (addr_l[17:16] == IO_HI) && bus.io_buffer_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            nbytes        <= '0;
            addr_l        <= '0;
            wdata_l       <= '0;
            rbuf          <= '0;
            is_fetch      <= 1'b0;
            bus.lsb_ok    <= 1'b0;
            bus.lsb_rdata <= '0;
            bus.if_ok     <= 1'b0;
            bus.if_data   <= '0;
            bus.mem_a     <= '0;
            bus.mem_dout  <= '0;
            bus.mem_wr    <= 1'b0;
        end else if (!rdy) begin
            // Frozen: hold everything, but never leave a write strobe asserted.
            bus.mem_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.lsb_req) begin
                        addr_l    <= bus.lsb_addr;
                        wdata_l   <= bus.lsb_wdata;
                        nbytes    <= op_bytes(bus.lsb_op);
                        is_fetch  <= 1'b0;
                        rbuf      <= '0;
                        bus.mem_a <= bus.lsb_addr;
                        if (lsb_store) begin
                            state        <= WRITE;
                            bus.mem_dout <= word_byte(bus.lsb_wdata, 2'd0);
                            if (lsb_stall) begin
                                // Byte 0 not launched yet; WRITE retries it.
                                bus.mem_wr <= 1'b0;
                                cnt        <= 3'd0;
                            end else begin
                                bus.mem_wr <= 1'b1;
                                cnt        <= 3'd1;
                            end
                        end else begin
                            state      <= READ;
                            bus.mem_wr <= 1'b0;
                            cnt        <= 3'd0;
                        end
                    end else if (bus.if_req) begin
                        addr_l     <= bus.if_addr;
                        nbytes     <= 3'd4;
                        is_fetch   <= 1'b1;
                        rbuf       <= '0;
                        bus.mem_a  <= bus.if_addr;
                        bus.mem_wr <= 1'b0;
                        cnt        <= 3'd0;
                        state      <= READ;
                    end
                end

                READ: begin
                    bus.mem_a <= bus.mem_a + ADDR_W'(1);
                    cnt       <= cnt + 3'd1;
                    if (cnt != 3'd0) begin
                        rbuf <= rbuf_next;
                        if (cnt == nbytes) begin
                            state <= DONE;
                            if (is_fetch) begin
                                bus.if_ok   <= 1'b1;
                                bus.if_data <= rbuf_next;
                            end else begin
                                bus.lsb_ok    <= 1'b1;
                                bus.lsb_rdata <= rbuf_next;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (cnt == nbytes) begin
                        state      <= DONE;
                        bus.mem_wr <= 1'b0;
                        bus.lsb_ok <= 1'b1;
                    end else if (wr_stall) begin
                        bus.mem_wr <= 1'b0;
                    end else begin
                        // Address derived from the byte index so a stall in
                        // front of any byte cannot skew it.
                        bus.mem_a    <= addr_l + ADDR_W'(cnt);
                        bus.mem_dout <= word_byte(wdata_l, cnt[1:0]);
                        bus.mem_wr   <= 1'b1;
                        cnt          <= cnt + 3'd1;
                    end
                end

                DONE: begin
                    bus.lsb_ok <= 1'b0;
                    bus.if_ok  <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
